// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requester FIFOs, the arbiter and uart_tx.
// The master modport is the arbiter side; slave is the requester/uart_tx side.
interface uart_tx_arbiter_if #(
    parameter int num_req_p   = 4,
    parameter int data_bits_p = 8
);
    logic [num_req_p-1:0]             req_v_i;
    logic [num_req_p*data_bits_p-1:0] req_data_i;
    logic [num_req_p-1:0]             req_last_i;
    logic [num_req_p-1:0]             req_ready_and_o;
    logic                             uart_v_o;
    logic [data_bits_p-1:0]           uart_data_o;
    logic                             uart_ready_and_i;
    logic                             uart_done_i;

    modport master (
        input  req_v_i, req_data_i, req_last_i, uart_ready_and_i, uart_done_i,
        output req_ready_and_o, uart_v_o, uart_data_o
    );

    modport slave (
        output req_v_i, req_data_i, req_last_i, uart_ready_and_i, uart_done_i,
        input  req_ready_and_o, uart_v_o, uart_data_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one uart_tx among num_req_p requesters.
// Define UART_TX_ARB_TAG_EN to prefix every grant with a tag byte carrying the requester index.
module uart_tx_arbiter #(
    parameter int num_req_p   = 4,
    parameter int data_bits_p = 8,
    parameter int max_burst_p = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    uart_tx_arbiter_if.master    bus_if,
    output logic [num_req_p-1:0] grant_o,
    output logic                 busy_o
);

    localparam int idx_w = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int cnt_w = $clog2(max_burst_p + 1);

`ifdef UART_TX_ARB_TAG_EN
    typedef enum logic [2:0] {e_idle, e_send, e_wait_done, e_tag, e_tag_wait} state_e;

    if (data_bits_p < $clog2(num_req_p)) begin : g_tag_width_check
        $error("uart_tx_arbiter: data_bits_p too narrow to carry the requester tag");
    end
`else
    typedef enum logic [1:0] {e_idle, e_send, e_wait_done} state_e;
`endif

    state_e               state_r;
    logic [idx_w-1:0]     gidx_r;
    logic [idx_w-1:0]     last_grant_r;
    logic [cnt_w-1:0]     cnt_r;
    logic                 last_r;

    logic                 pick_found;
    logic [idx_w-1:0]     pick_idx;
    logic                 own_v;
    logic                 own_last;
    logic [data_bits_p-1:0] own_data;

    assign own_v    = bus_if.req_v_i[gidx_r];
    assign own_last = bus_if.req_last_i[gidx_r];
    assign own_data = bus_if.req_data_i[gidx_r*data_bits_p +: data_bits_p];

    // Search starts just past the previous owner so it ends up lowest priority.
    always_comb begin
        int unsigned cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned i = 1; i <= num_req_p; i++) begin
            cand = (int'(last_grant_r) + i) % num_req_p;
            if (!pick_found && bus_if.req_v_i[idx_w'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = idx_w'(cand);
            end
        end
    end

    always_comb begin
        bus_if.uart_v_o        = 1'b0;
        bus_if.uart_data_o     = '0;
        bus_if.req_ready_and_o = '0;
        case (state_r)
            e_send: begin
                bus_if.uart_v_o        = own_v;
                bus_if.uart_data_o     = own_v ? own_data : '0;
                bus_if.req_ready_and_o = grant_o & {num_req_p{bus_if.uart_ready_and_i}};
            end
`ifdef UART_TX_ARB_TAG_EN
            e_tag: begin
                bus_if.uart_v_o    = 1'b1;
                bus_if.uart_data_o = data_bits_p'(gidx_r);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r      <= e_idle;
            grant_o      <= '0;
            busy_o       <= 1'b0;
            gidx_r       <= '0;
            last_grant_r <= idx_w'(num_req_p - 1);
            cnt_r        <= '0;
            last_r       <= 1'b0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (pick_found) begin
                        grant_o <= num_req_p'(1) << pick_idx;
                        gidx_r  <= pick_idx;
                        cnt_r   <= '0;
                        busy_o  <= 1'b1;
`ifdef UART_TX_ARB_TAG_EN
                        state_r <= e_tag;
`else
                        state_r <= e_send;
`endif
                    end
                end
                e_send: begin
                    if (bus_if.uart_v_o && bus_if.uart_ready_and_i) begin
                        last_r  <= own_last;
                        cnt_r   <= cnt_r + cnt_w'(1);
                        state_r <= e_wait_done;
                    end
                end
                e_wait_done: begin
                    if (bus_if.uart_done_i) begin
                        if (last_r || (cnt_r == cnt_w'(max_burst_p))) begin
                            last_grant_r <= gidx_r;
                            grant_o      <= '0;
                            busy_o       <= 1'b0;
                            state_r      <= e_idle;
                        end else begin
                            state_r <= e_send;
                        end
                    end
                end
`ifdef UART_TX_ARB_TAG_EN
                e_tag: begin
                    if (bus_if.uart_ready_and_i) state_r <= e_tag_wait;
                end
                e_tag_wait: begin
                    if (bus_if.uart_done_i) state_r <= e_send;
                end
`endif
                default: state_r <= e_idle;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between num_req_p byte-stream requesters (console, debug monitor, status reporter, ...).
- Round-robin arbitration at packet granularity. A packet is a run of bytes ending in a last flag, and it is capped at max_burst_p bytes.
- Drives uart_tx's tx_v_i/tx_i. Sequences each byte by waiting for uart_tx's tx_done_o before issuing the next byte.
- Sits between the requester FIFOs and uart_tx in the board top level.

Parameters:
- num_req_p, 4, number of requesters (2-16).
- data_bits_p, 8, byte width; must match uart_tx data_bits_p.
- max_burst_p, 16, max bytes sent per grant before forced re-arbitration (>=1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset. Asynchronous, active-high.
- req_v_i  in  num_req_p  per-requester byte valid.
- req_data_i  in  num_req_p*data_bits_p  per-requester byte; requester i occupies slice [i*data_bits_p +: data_bits_p].
- req_last_i  in  num_req_p  byte is the last of its packet.
- req_ready_and_o  out  num_req_p  byte accepted when req_v_i[i] & req_ready_and_o[i].
- uart_v_o  out  1  to uart_tx tx_v_i.
- uart_data_o  out  data_bits_p  to uart_tx tx_i.
- uart_ready_and_i  in  1  from uart_tx tx_ready_and_o.
- uart_done_i  in  1  from uart_tx tx_done_o (1-cycle pulse).
- grant_o  out  num_req_p  one-hot current owner; 0 when idle.
- busy_o  out  1  high in every state except e_idle.

Behaviour:
- Reset values:
  - state=e_idle; grant_o=0; uart_v_o=0; req_ready_and_o=0; busy_o=0.
  - Byte counter=0; last-grant pointer=num_req_p-1, so requester 0 wins first.
- Reset mid-operation: everything above returns to its reset value immediately (asynchronous). The byte in flight is abandoned; uart_tx shares the same reset.
- States:
  - e_idle: if |req_v_i, pick the first set bit searching from last_grant+1 upward with wrap-around. Register the one-hot grant, clear the byte counter, go to e_send. Latency: req_v_i seen in cycle t gives grant_o and uart_v_o in t+1.
  - e_send:
    - uart_v_o = req_v_i[g]; uart_data_o = data slice of g; req_ready_and_o[g] = uart_ready_and_i; all other ready bits 0.
    - On handshake (uart_v_o & uart_ready_and_i): register req_last_i[g], increment the byte counter, go to e_wait_done.
    - If the owner drops valid, hold the grant and wait; there is no timeout.
  - e_wait_done: uart_v_o=0; all ready bits 0. On uart_done_i:
    - If the registered last flag is set, or counter==max_burst_p: set last_grant=g, clear grant_o, go to e_idle.
    - Otherwise go to e_send.
- uart_done_i outside e_wait_done is ignored.
- At most one byte is outstanding in uart_tx at any time.
- Fairness: after a release, the releasing requester has the lowest priority. A requester with continuous packets yields after every packet or every max_burst_p bytes.
- Simultaneous requests in e_idle: exactly one grant, chosen by the round-robin order. The losers see ready=0.
- Counter width: clog2(max_burst_p+1). The counter saturates by construction and never wraps.
- uart_data_o = 0 whenever uart_v_o = 0.

Optional Feature:
- Macro: UART_TX_ARB_TAG_EN.
- When defined:
  - e_idle moves to an extra state e_tag before e_send.
  - e_tag drives uart_v_o=1 with uart_data_o = the granted index, zero-extended to data_bits_p. All req_ready_and_o are 0.
  - After the tag handshake, wait for uart_done_i, then go to e_send.
  - The tag byte is not counted toward max_burst_p. It is sent once per grant, so a packet split by the burst cap gets a fresh tag on its next grant.
  - Elaboration error if data_bits_p < clog2(num_req_p).
- When undefined: no e_tag state and no tag logic.

Test Plan:
- Single requester: req 1 sends 3 bytes 0x41,0x42,0x43 with last on 0x43 → uart_tx serial line shows exactly those 3 frames in order. grant_o=4'b0010 throughout; after the 3rd uart_done_i, grant_o=0 and busy_o=0.
- Contention: reqs 0 and 2 assert together from reset, each with a 2-byte packet → req 0's packet is sent fully, then req 2's. No interleaving of bytes.
- Round-robin: reqs 0,1,3 continuously send 1-byte packets → grant sequence 0,1,3,0,1,3.
- Burst cap: max_burst_p=4, req 0 sends a 10-byte packet while req 1 waits → order is 4 bytes of req 0, req 1's packet, 4 bytes of req 0, req 1's next packet (if pending), then 2 bytes of req 0.
- Stall and reset: owner drops req_v_i for 50 cycles mid-packet → uart_v_o stays 0 and the grant is held. Assert reset_i asynchronously during e_wait_done → all outputs reach reset values before the next clock edge, and requester 0 wins next.
- With UART_TX_ARB_TAG_EN: req 2 sends byte 0x55 (last) → frames 0x02 then 0x55 appear on the line; req_ready_and_o[2] stays 0 during the tag.
